minmax_tracker: RTL and testbench



---
 rtl/minmax_pkg.sv | 12 +
 rtl/extremum_update.sv | 32 +++
 rtl/minmax_tracker.sv | 130 +++++++++++++
 tb/tb_minmax_tracker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// Shared definitions for the streaming min/max tracker.
package minmax_pkg;

  localparam int unsigned DEF_DATAWIDTH = 8;
  localparam int unsigned DEF_IDXWIDTH  = 8;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/extremum_update.sv
// Combinational running-extremum step; MAX_MODE picks strict-greater, else strict-less.
module extremum_update
  import minmax_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
  parameter int unsigned IDXWIDTH  = DEF_IDXWIDTH,
  parameter bit          MAX_MODE  = 1'b0
) (
  input  logic [DATAWIDTH-1:0] cur_val,
  input  logic [IDXWIDTH-1:0]  cur_idx,
  input  logic [DATAWIDTH-1:0] cand_val,
  input  logic [IDXWIDTH-1:0]  cand_idx,
  input  logic                 first,
  output logic [DATAWIDTH-1:0] next_val,
  output logic [IDXWIDTH-1:0]  next_idx
);

  logic better;

  always_comb begin
    // Strict compare keeps the earliest index on ties.
    better = MAX_MODE ? (cand_val > cur_val) : (cand_val < cur_val);
    if (first || better) begin
      next_val = cand_val;
      next_idx = cand_idx;
    end else begin
      next_val = cur_val;
      next_idx = cur_idx;
    end
  end

endmodule

// File: rtl/minmax_tracker.sv
// Frame-level min/max/index/count tracker with valid/ready input and result handshakes.
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
  parameter int unsigned IDXWIDTH  = DEF_IDXWIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_min,
  output logic [DATAWIDTH-1:0] out_max,
  output logic [IDXWIDTH-1:0]  out_min_idx,
  output logic [IDXWIDTH-1:0]  out_max_idx,
  output logic [IDXWIDTH-1:0]  out_count,
  output logic                 out_ovf
);

  state_t state_q, state_d;

  logic                 run_q;
  logic                 first_q;
  logic                 ovf_q;
  logic [IDXWIDTH-1:0]  idx_q;
  logic [DATAWIDTH-1:0] min_q, max_q;
  logic [IDXWIDTH-1:0]  min_idx_q, max_idx_q;

  logic                 accept;
  logic [IDXWIDTH-1:0]  sample_idx;
  logic                 ovf_next;
  logic [DATAWIDTH-1:0] min_next, max_next;
  logic [IDXWIDTH-1:0]  min_idx_next, max_idx_next;

  extremum_update #(
    .DATAWIDTH (DATAWIDTH),
    .IDXWIDTH  (IDXWIDTH),
    .MAX_MODE  (1'b0)
  ) u_min (
    .cur_val  (min_q),
    .cur_idx  (min_idx_q),
    .cand_val (in_data),
    .cand_idx (sample_idx),
    .first    (first_q),
    .next_val (min_next),
    .next_idx (min_idx_next)
  );

  extremum_update #(
    .DATAWIDTH (DATAWIDTH),
    .IDXWIDTH  (IDXWIDTH),
    .MAX_MODE  (1'b1)
  ) u_max (
    .cur_val  (max_q),
    .cur_idx  (max_idx_q),
    .cand_val (in_data),
    .cand_idx (sample_idx),
    .first    (first_q),
    .next_val (max_next),
    .next_idx (max_idx_next)
  );

  // run_q holds in_ready low until the first edge after reset release.
  assign in_ready   = run_q && (state_q == ST_ACCUM);
  assign out_valid  = (state_q == ST_HOLD);
  assign accept     = in_valid && in_ready;
  assign sample_idx = first_q ? '0 : idx_q;
  // Sticky overflow: set when the index wraps from all-ones back to 0.
  assign ovf_next   = (!first_q && ovf_q) || (sample_idx == '1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACCUM: if (accept && in_last) state_d = ST_HOLD;
      ST_HOLD:  if (out_ready) state_d = ST_ACCUM;
      default:  state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      run_q       <= 1'b0;
      first_q     <= 1'b1;
      ovf_q       <= 1'b0;
      idx_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      min_idx_q   <= '0;
      max_idx_q   <= '0;
      out_min     <= '0;
      out_max     <= '0;
      out_min_idx <= '0;
      out_max_idx <= '0;
      out_count   <= '0;
      out_ovf     <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        min_q     <= min_next;
        max_q     <= max_next;
        min_idx_q <= min_idx_next;
        max_idx_q <= max_idx_next;
        idx_q     <= sample_idx + 1'b1;
        ovf_q     <= ovf_next;
        first_q   <= in_last;
        if (in_last) begin
          out_min     <= min_next;
          out_max     <= max_next;
          out_min_idx <= min_idx_next;
          out_max_idx <= max_idx_next;
          out_count   <= sample_idx + 1'b1;
          out_ovf     <= ovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_minmax_tracker.sv
// Scoreboard bench for minmax_tracker: a wide-index instance (a) and a 2-bit-index instance (b).
module tb_minmax_tracker;

  typedef struct packed {
    logic [7:0] mn;
    logic [7:0] mx;
    logic [7:0] mi;
    logic [7:0] xi;
    logic [7:0] cnt;
    logic       ovf;
  } res_t;

  logic clk;
  logic rst;

  logic       in_valid_a, in_ready_a, in_last_a, out_valid_a, out_ready_a, out_ovf_a;
  logic [7:0] in_data_a, out_min_a, out_max_a, out_min_idx_a, out_max_idx_a, out_count_a;

  logic       in_valid_b, in_ready_b, in_last_b, out_valid_b, out_ready_b, out_ovf_b;
  logic [7:0] in_data_b, out_min_b, out_max_b;
  logic [1:0] out_min_idx_b, out_max_idx_b, out_count_b;

  int checks   = 0;
  int failures = 0;

  res_t       qa[$];
  res_t       qb[$];
  logic [7:0] fr[$];
  res_t       act_a, act_b;
  bit         rnd_mode     = 1'b0;
  logic       ready_manual = 1'b1;

  minmax_tracker #(.DATAWIDTH(8), .IDXWIDTH(8)) dut_a (
    .Clk         (clk),
    .Rst         (rst),
    .in_valid    (in_valid_a),
    .in_ready    (in_ready_a),
    .in_data     (in_data_a),
    .in_last     (in_last_a),
    .out_valid   (out_valid_a),
    .out_ready   (out_ready_a),
    .out_min     (out_min_a),
    .out_max     (out_max_a),
    .out_min_idx (out_min_idx_a),
    .out_max_idx (out_max_idx_a),
    .out_count   (out_count_a),
    .out_ovf     (out_ovf_a)
  );

  minmax_tracker #(.DATAWIDTH(8), .IDXWIDTH(2)) dut_b (
    .Clk         (clk),
    .Rst         (rst),
    .in_valid    (in_valid_b),
    .in_ready    (in_ready_b),
    .in_data     (in_data_b),
    .in_last     (in_last_b),
    .out_valid   (out_valid_b),
    .out_ready   (out_ready_b),
    .out_min     (out_min_b),
    .out_max     (out_max_b),
    .out_min_idx (out_min_idx_b),
    .out_max_idx (out_max_idx_b),
    .out_count   (out_count_b),
    .out_ovf     (out_ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Reference model over the current frame in fr, for index width w.
  function automatic res_t model(input int w);
    res_t r;
    int   m = (1 << w) - 1;
    r.mn  = fr[0];
    r.mx  = fr[0];
    r.mi  = 8'd0;
    r.xi  = 8'd0;
    for (int i = 1; i < fr.size(); i++) begin
      if (fr[i] < r.mn) begin r.mn = fr[i]; r.mi = 8'(i & m); end
      if (fr[i] > r.mx) begin r.mx = fr[i]; r.xi = 8'(i & m); end
    end
    r.cnt = 8'(fr.size() & m);
    r.ovf = (fr.size() >= (1 << w));
    return r;
  endfunction

  task automatic drive(input bit b, input logic v, input logic [7:0] d, input logic l);
    if (b) begin in_valid_b = v; in_data_b = d; in_last_b = l; end
    else   begin in_valid_a = v; in_data_a = d; in_last_a = l; end
  endtask

  // Sends fr; returns one step after the edge that accepted the final sample.
  task automatic send(input bit b, input bit with_last, input bit use_model, input int gap_pct);
    int n = fr.size();
    int bound;
    if (use_model) begin
      if (b) qb.push_back(model(2));
      else   qa.push_back(model(8));
    end
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        drive(b, 1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
        @(posedge clk); #1;
      end
      drive(b, 1'b1, fr[i], with_last && (i == n - 1));
      @(negedge clk);
      bound = 0;
      while (!(b ? in_ready_b : in_ready_a)) begin
        @(negedge clk);
        bound++;
        if (bound > 100) begin
          check("in_ready_timeout", 64'd0, 64'd1);
          break;
        end
      end
      @(posedge clk); #1;
    end
    drive(b, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    out_ready_a = 1'b0;
    out_ready_b = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready_a = rnd_mode ? 1'($urandom_range(0, 1)) : ready_manual;
      out_ready_b = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready_a) begin
      act_a = '{out_min_a, out_max_a, out_min_idx_a, out_max_idx_a, out_count_a, out_ovf_a};
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL res_a_unexpected actual=%0h required=none", act_a);
      end else begin
        check("res_a", act_a, qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_b && out_ready_b) begin
      act_b = '{out_min_b, out_max_b, {6'd0, out_min_idx_b}, {6'd0, out_max_idx_b},
                {6'd0, out_count_b}, out_ovf_b};
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL res_b_unexpected actual=%0h required=none", act_b);
      end else begin
        check("res_b", act_b, qb.pop_front());
      end
    end
  end

  initial begin
    int bound;
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    drive(1'b1, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready_a", in_ready_a, 0);
    check("rst_in_ready_b", in_ready_b, 0);
    check("rst_outs_a", {out_valid_a, out_min_a, out_max_a, out_min_idx_a, out_max_idx_a,
                         out_count_a, out_ovf_a}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready_a", in_ready_a, 1);
    check("post_rst_outs_a", {out_valid_a, out_max_a, out_count_a}, 0);

    // 5,2,9,2,9: ties keep the earliest index.
    qa.push_back('{8'd2, 8'd9, 8'd1, 8'd2, 8'd5, 1'b0});
    fr = {8'd5, 8'd2, 8'd9, 8'd2, 8'd9};
    send(1'b0, 1'b1, 1'b0, 0);
    check("t1_latency_valid", out_valid_a, 1);
    check("t1_in_ready_hold", in_ready_a, 0);

    // Single 0xFF held with out_ready low.
    @(negedge clk);
    ready_manual = 1'b0;
    qa.push_back('{8'hFF, 8'hFF, 8'd0, 8'd0, 8'd1, 1'b0});
    fr = {8'hFF};
    send(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_hold", {in_ready_a, out_valid_a, out_min_a, out_max_a, out_min_idx_a,
                        out_max_idx_a, out_count_a, out_ovf_a},
            {1'b0, 1'b1, 8'hFF, 8'hFF, 8'd0, 8'd0, 8'd1, 1'b0});
    end
    ready_manual = 1'b1;
    @(negedge clk);
    ready_manual = 1'b0;
    check("t2_no_bypass", in_ready_a, 0);
    @(negedge clk);
    check("t2_ready_after", {in_ready_a, out_valid_a}, 2'b10);
    ready_manual = 1'b1;

    // Unsigned compare across the MSB.
    qa.push_back('{8'h7F, 8'h80, 8'd1, 8'd0, 8'd2, 1'b0});
    fr = {8'h80, 8'h7F};
    send(1'b0, 1'b1, 1'b0, 0);

    // 2-bit index: a 4-sample frame wraps the count and sets ovf; the next frame clears it.
    qb.push_back('{8'd0, 8'd7, 8'd2, 8'd3, 8'd0, 1'b1});
    fr = {8'd3, 8'd1, 8'd0, 8'd7};
    send(1'b1, 1'b1, 1'b0, 0);
    qb.push_back('{8'd5, 8'd5, 8'd0, 8'd0, 8'd1, 1'b0});
    fr = {8'd5};
    send(1'b1, 1'b1, 1'b0, 0);

    // Reset after three samples discards the partial frame.
    fr = {8'd1, 8'd2, 8'd3};
    send(1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", {in_ready_a, in_ready_b}, 0);
    check("mid_rst_outs", {out_valid_a, out_min_a, out_max_a, out_min_idx_a, out_max_idx_a,
                           out_count_a, out_ovf_a}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_release", in_ready_a, 1);
    qa.push_back('{8'd4, 8'd4, 8'd0, 8'd0, 8'd2, 1'b0});
    fr = {8'd4, 8'd4};
    send(1'b0, 1'b1, 1'b0, 0);

    // 257 samples on the 8-bit index: count wraps to 1 with ovf sticky.
    fr.delete();
    for (int i = 0; i < 257; i++) fr.push_back(8'($urandom));
    send(1'b0, 1'b1, 1'b1, 0);

    rnd_mode = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      int n = $urandom_range(1, 6);
      fr.delete();
      for (int i = 0; i < n; i++) begin
        fr.push_back((f % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom));
      end
      send(1'b0, 1'b1, 1'b1, 30);
    end

    bound = 0;
    while ((qa.size() != 0 || qb.size() != 0) && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
